// File: rtl/collector_pkg.sv
// collector_pkg: shared FSM states, field widths and the saturating counter helper
// used by packet_collector and its statistics block.
package collector_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DROP} coll_state_t;
    localparam int PORTW = 4;
    localparam int WORDW = 8;
    // Increments v, holding at 2^w-1 for a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        return (v == (32'd1 << w) - 32'd1) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/packet_collector_if.sv
// packet_collector_if: serial payload input, assembled-word output and statistics
// read port of the packet collector.
interface packet_collector_if #(parameter int CNTW = 8);
    import collector_pkg::*;
    logic             sin;
    logic             outvalid;
    logic             error;
    logic [PORTW-1:0] p;
    logic [WORDW-1:0] word_out;
    logic [PORTW-1:0] word_port;
    logic             word_valid;
    logic             word_partial;
    logic             frame_done;
    logic             frame_err;
    logic [PORTW-1:0] rd_port;
    logic [CNTW-1:0]  rd_words;
    logic [CNTW-1:0]  err_count;
    modport master (
        output sin, outvalid, error, p, rd_port,
        input  word_out, word_port, word_valid, word_partial, frame_done, frame_err,
               rd_words, err_count
    );
    modport slave (
        input  sin, outvalid, error, p, rd_port,
        output word_out, word_port, word_valid, word_partial, frame_done, frame_err,
               rd_words, err_count
    );
endinterface

// File: rtl/port_stats.sv
// port_stats: per-port saturating word counters with a combinational read mux.
module port_stats import collector_pkg::*; #(
    parameter int NPORTS = 16,
    parameter int CNTW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [PORTW-1:0] inc_idx,
    input  logic [PORTW-1:0] rd_idx,
    output logic [CNTW-1:0]  rd_cnt
);
    logic [CNTW-1:0] cnt [NPORTS];
    always_ff @(posedge clk)
        if (rst)
            for (int i = 0; i < NPORTS; i++) cnt[i] <= '0;
        else if (inc)
            cnt[inc_idx] <= CNTW'(sat_inc(32'(cnt[inc_idx]), CNTW));
    assign rd_cnt = cnt[rd_idx];
endmodule

// File: rtl/packet_collector.sv
// packet_collector: packs the controller's serial payload MSB-first into port-tagged
// 8-bit words, flushing a zero-padded partial word at frame end; counts words and drops.
module packet_collector import collector_pkg::*; #(
    parameter int NPORTS = 16,
    parameter int CNTW   = 8
) (
    input logic clk,
    input logic rst,
    packet_collector_if.slave bus
);
    coll_state_t      state, state_n;
    logic [WORDW-1:0] sr, sr_n, shifted, emit_word;
    logic [2:0]       cnt, cnt_n;
    logic [PORTW-1:0] port_r, port_n;
    logic             emit, partial, done, ferr;
    logic [CNTW-1:0]  err_cnt;
    assign shifted = {sr[WORDW-2:0], bus.sin};
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = cnt;
        port_n    = port_r;
        emit      = 1'b0;
        partial   = 1'b0;
        done      = 1'b0;
        ferr      = 1'b0;
        // Left-justify the k collected bits for a flush; k = 0 shifts everything out.
        emit_word = sr << (4'(WORDW) - {1'b0, cnt});
        case (state)
            IDLE:
                if (bus.outvalid && bus.error) begin
                    state_n = DROP;
                    ferr    = 1'b1;
                end else if (bus.outvalid) begin
                    state_n = COLLECT;
                    port_n  = bus.p;
                    sr_n    = {{(WORDW-1){1'b0}}, bus.sin};
                    cnt_n   = 3'd1;
                end
            COLLECT:
                if (bus.error) begin
                    state_n = DROP;
                    ferr    = 1'b1;
                    sr_n    = '0;
                    cnt_n   = '0;
                end else if (bus.outvalid) begin
                    sr_n      = shifted;
                    cnt_n     = cnt + 3'd1;
                    emit      = cnt == 3'd7;
                    emit_word = cnt == 3'd7 ? shifted : emit_word;
                end else begin
                    state_n = IDLE;
                    done    = 1'b1;
                    emit    = cnt != 3'd0;
                    partial = cnt != 3'd0;
                    sr_n    = '0;
                    cnt_n   = '0;
                end
            DROP:
                state_n = (!bus.outvalid && !bus.error) ? IDLE : DROP;
            default:
                state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            sr               <= '0;
            cnt              <= '0;
            port_r           <= '0;
            err_cnt          <= '0;
            bus.word_out     <= '0;
            bus.word_port    <= '0;
            bus.word_valid   <= 1'b0;
            bus.word_partial <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.frame_err    <= 1'b0;
        end else begin
            state            <= state_n;
            sr               <= sr_n;
            cnt              <= cnt_n;
            port_r           <= port_n;
            bus.word_valid   <= emit;
            bus.word_partial <= partial;
            bus.frame_done   <= done;
            bus.frame_err    <= ferr;
            if (emit) begin
                bus.word_out  <= emit_word;
                bus.word_port <= port_r;
            end
            if (ferr) err_cnt <= CNTW'(sat_inc(32'(err_cnt), CNTW));
        end
    end
    assign bus.err_count = err_cnt;
    port_stats #(.NPORTS(NPORTS), .CNTW(CNTW)) u_stats (
        .clk     (clk),
        .rst     (rst),
        .inc     (emit),
        .inc_idx (port_r),
        .rd_idx  (bus.rd_port),
        .rd_cnt  (bus.rd_words)
    );
endmodule

// File: doc/packet_collector.md
# packet_collector

Downstream stage of the serial packet controller. Consumes the controller's serial payload bit stream (`sin`), qualified by the controller's `outvalid`/`error` and its decoded destination port `p[3:0]`. Packs payload bits MSB-first into 8-bit words tagged with the destination port. Keeps per-port word statistics and an error count for the bench and for any downstream sink.

## Interface
Parameters:
- `NPORTS`, 16: number of destination ports; the port field is `$clog2(NPORTS)` = 4 bits.
- `CNTW`, 8: width of the statistics counters. All counters saturate.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; **one clock, reset synchronous and active-high**.
- `sin`  in  1  payload bit, the same serial line the controller samples.
- `p`  in  4  destination port from the controller.
- `outvalid`  in  1  high while `sin` carries a payload bit.
- `error`  in  1  controller framing error, level.
- `word_out`  out  8  assembled word.
- `word_port`  out  4  port of `word_out`.
- `word_valid`  out  1  one-cycle strobe for `word_out`/`word_port`.
- `word_partial`  out  1  high with `word_valid` when the word is zero-padded.
- `frame_done`  out  1  one-cycle pulse at a clean frame end.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped.
- `rd_port`  in  4  statistics read select.
- `rd_words`  out  CNTW  word count of port `rd_port`. Combinational read.
- `err_count`  out  CNTW  dropped-frame count.

## Operation
- States: IDLE, COLLECT, DROP.
- IDLE:
  - `outvalid`=1 and `error`=0: latch `p` into the port register, shift `sin` in as bit 7, set the bit count to 1, go to COLLECT.
  - `outvalid`=1 and `error`=1: go to DROP and pulse `frame_err`.
- COLLECT, `outvalid`=1 and `error`=0:
  - Shift `sin` in MSB-first.
  - On the 8th bit, register the word, strobe `word_valid`, and reset the bit count to 0.
  - `p` changes during the frame are ignored; the port is sampled only at frame start.
- COLLECT, `outvalid` falls with `error`=0:
  - Bit count = 0: pulse `frame_done`.
  - Bit count = k > 0: emit the k collected bits in `word_out[7:8-k]`, zeros below, with `word_valid`=1, `word_partial`=1, and `frame_done`=1 in the same cycle.
  - In both cases go to IDLE.
- `error`=1 in COLLECT (takes precedence over everything else in the same cycle):
  - Discard the partial word; emit no word for the current bit.
  - Pulse `frame_err`, increment `err_count`, go to DROP.
  - Words already emitted in this frame stay counted.
- DROP: return to IDLE on the first cycle with `outvalid`=0 and `error`=0.
- Statistics:
  - `rd_words[port]` increments on every `word_valid`, partial words included.
  - `err_count` increments on every `frame_err`, including a drop entered from IDLE.
  - Both saturate at 2^CNTW−1.
- Reset:
  - State returns to IDLE.
  - Shift register, bit count, port register, all counters and all outputs are cleared to 0.
  - Reset mid-frame discards the frame silently: no `frame_err`, no count.

## Timing
- All outputs are registered except `rd_words`.
- Latency: the 8th bit sampled at edge N gives `word_valid` high in cycle N+1, for exactly one cycle.
- Frame end: `outvalid` seen low at edge N gives the flush word and/or `frame_done` in cycle N+1.
- Back-to-back frames:
  - `outvalid` may re-rise on the cycle right after the fall; IDLE samples the new first bit on that edge.
  - Zero bubble; the new frame's first word cannot collide with the previous frame's flush.
- Sustained one bit per cycle is supported; `word_valid` has a minimum spacing of 8 cycles within a frame.
- No backpressure: the sink must accept every strobe.

## Structure
- Package `collector_pkg`:
  - `typedef enum logic [1:0] {IDLE, COLLECT, DROP} coll_state_t`
  - `PORTW` = 4 and `WORDW` = 8 localparams
  - a saturating-increment function shared by both counters
- Sub-module `port_stats`: a 16×CNTW saturating counter array with an increment strobe, an increment index, the `rd_port` read mux, and synchronous clear on `rst`.
- Everything else (FSM, shifter, bit counter, output registers) stays in `packet_collector`.

## Test plan
- Reset, then `p`=5 with `outvalid` high for 8 cycles and `sin`=1,0,1,1,0,0,1,0 → one `word_valid` with `word_out`=8'hB2, `word_port`=5, `word_partial`=0. Then `frame_done` one cycle later, and `rd_words`(5)=1.
- `p`=3 with 11 bits 1,1,1,1,0,0,0,0,1,0,1 → 8'hF0 (full), then 8'hA0 with `word_partial`=1 and `frame_done` in the same cycle; `rd_words`(3)=2.
- `p`=9 with `error` raised at the 5th bit → no word, `frame_err` pulse, `err_count`=1. `outvalid` held for 3 more cycles → no output until the next frame.
- Two frames to ports 1 then 2, separated by a single low cycle of `outvalid` → two `frame_done` pulses, each word carrying the correct port.
- `p` toggled from 4 to 6 mid-frame → all words tagged 4.
- 300 frames of 8 bits to port 0 → `rd_words`(0) saturates at 255. Then `rst` asserted for one cycle → `rd_words`(0)=0, `err_count`=0, all strobes low.
